// File: rtl/pm_exec_ctrl.sv
// Execute controller for a 4-bit combinational ALU: 4x4 register file, IDLE->EXEC->DONE sequencing, Z/C flags.
// Optional macro PM_EXEC_CARRY_CHAIN_EN: the instruction cin bit selects the previous carry instead of a literal.
module pm_exec_ctrl #(
  parameter int DW      = 4,
  parameter int AW      = 2,
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [14:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_s,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_y,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          z_flag,
  output logic          c_flag,
  output logic          busy,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state_q, state_d;
  logic [14:0]   ireg_q, ireg_d;
  logic [DW-1:0] regs_q [2**AW];
  logic [DW-1:0] regs_d [2**AW];
  logic [DW-1:0] result_q, result_d;
  logic          z_q, z_d;
  logic          c_q, c_d;
  logic [DW:0]   sum_add, sum_sub;

  logic [2:0]    i_op;
  logic [AW-1:0] i_dst, i_srca, i_srcb;
  logic          i_cin, i_useimm;
  logic [DW-1:0] i_imm;

  assign i_op     = ireg_q[14:12];
  assign i_dst    = AW'(ireg_q[11:10]);
  assign i_srca   = AW'(ireg_q[9:8]);
  assign i_srcb   = AW'(ireg_q[7:6]);
  assign i_cin    = ireg_q[5];
  assign i_useimm = ireg_q[4];
  assign i_imm    = DW'(ireg_q[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ireg_q   <= '0;
      regs_q   <= '{default: DW'(RST_VAL)};
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ireg_q   <= ireg_d;
      regs_q   <= regs_d;
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ireg_d   = ireg_q;
    regs_d   = regs_q;
    result_d = result_q;
    z_d      = z_q;
    c_d      = c_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_s    = 3'b000;
    alu_cin  = 1'b0;
    sum_add  = '0;
    sum_sub  = '0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ireg_d  = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Operands come from regs_q, so dst==src reads the pre-write value.
        alu_a = regs_q[i_srca];
        alu_b = i_useimm ? i_imm : regs_q[i_srcb];
        alu_s = i_op;
`ifdef PM_EXEC_CARRY_CHAIN_EN
        alu_cin = i_cin ? c_q : 1'b0;
`else
        alu_cin = i_cin;
`endif
        sum_add = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
        sum_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + {{DW{1'b0}}, alu_cin};
        regs_d[i_dst] = alu_y;
        result_d      = alu_y;
        z_d           = (alu_y == '0);
        if (i_op == 3'b000) c_d = sum_add[DW];
        else if (i_op == 3'b001) c_d = sum_sub[DW];
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign z_flag       = z_q;
  assign c_flag       = c_q;
  assign rd_data      = regs_q[rd_addr];

endmodule

// File: tb/tb_pm_exec_ctrl.sv
// Scoreboard bench for pm_exec_ctrl: stimulus pushes hand-computed results, a negedge monitor pops and compares.
module tb_pm_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [14:0] instr;
  logic [3:0]  alu_a, alu_b, alu_y;
  logic [2:0]  alu_s;
  logic        alu_cin;
  logic [3:0]  result;
  logic        result_valid, z_flag, c_flag, busy;
  logic [1:0]  rd_addr;
  logic [3:0]  rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] y;
    logic       z;
    logic       c;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  pm_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_y(alu_y), .result(result), .result_valid(result_valid), .z_flag(z_flag),
    .c_flag(c_flag), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: 0 add, 1 sub, 2 pass b, 3 and, 4 or, 5 xor, 6 not a, 7 pass a.
  always_comb begin
    case (alu_s)
      3'd0:    alu_y = alu_a + alu_b + {3'b0, alu_cin};
      3'd1:    alu_y = alu_a + ~alu_b + {3'b0, alu_cin};
      3'd2:    alu_y = alu_b;
      3'd3:    alu_y = alu_a & alu_b;
      3'd4:    alu_y = alu_a | alu_b;
      3'd5:    alu_y = alu_a ^ alu_b;
      3'd6:    alu_y = ~alu_a;
      default: alu_y = alu_a;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic cin, input logic ui, input logic [3:0] imm);
    return {op, dst, sa, sb, cin, ui, imm};
  endfunction

  task automatic issue(input logic [14:0] w, input logic [3:0] ey, input logic ez, input logic ec, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr_ready stayed 0, required 1");
      instr_valid = 1'b0;
      return;
    end
    if (push) begin
      e.y = ey; e.z = ez; e.c = ec; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    $display("issue instr=%h exp_y=%h z=%b c=%b", w, ey, ez, ec);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !instr_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: result_valid with empty scoreboard, result=%h", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result y=%h z=%b c=%b cyc=%0d", result, z_flag, c_flag, cyc);
        chk("result", 32'(result), 32'(e.y));
        chk("z_flag", 32'(z_flag), 32'(e.z));
        chk("c_flag", 32'(c_flag), 32'(e.c));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int last;
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; rd_addr = '0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    chk("rst_zc", 32'({z_flag, c_flag}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);

    // Reset mid-EXEC discards the in-flight instruction and clears the file.
    issue(mk(3'd2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'd7), 4'd7, 1'b0, 1'b0, 1);
    drain();
    issue(mk(3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'd9), 4'd0, 1'b0, 1'b0, 0);
    chk("exec_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(instr_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1 chk("arst_reg", 32'(rd_data), 32'd0);
    end
    chk("arst_result", 32'(result), 32'd0);

    // R1=5, R2=3, R3=R1+R2
    issue(mk(3'd2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'd5), 4'd5, 1'b0, 1'b0, 1);
    issue(mk(3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'd3), 4'd3, 1'b0, 1'b0, 1);
    issue(mk(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'd0), 4'd8, 1'b0, 1'b0, 1);
    drain();
    rd_addr = 2'd3;
    #1 chk("rd_r3", 32'(rd_data), 32'd8);

    // 9+9 carries; 9-9 with cin=1 is zero with carry
    issue(mk(3'd2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'd9), 4'd9, 1'b0, 1'b0, 1);
    issue(mk(3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'd9), 4'd9, 1'b0, 1'b0, 1);
    issue(mk(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'd0), 4'd2, 1'b0, 1'b1, 1);
    issue(mk(3'd1, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 4'd0), 4'd0, 1'b1, 1'b1, 1);

    // Carry chain: c=1, 0+0+cin
    issue(mk(3'd2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'd0), 4'd0, 1'b1, 1'b1, 1);
    issue(mk(3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'd0), 4'd0, 1'b1, 1'b1, 1);
    issue(mk(3'd0, 2'd3, 2'd1, 2'd2, 1'b1, 1'b0, 4'd0), 4'd1, 1'b0, 1'b0, 1);
    issue(mk(3'd0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 4'd0), 4'd0, 1'b1, 1'b0, 1);
`ifdef PM_EXEC_CARRY_CHAIN_EN
    issue(mk(3'd0, 2'd3, 2'd1, 2'd2, 1'b1, 1'b0, 4'd0), 4'd0, 1'b1, 1'b0, 1);
`else
    issue(mk(3'd0, 2'd3, 2'd1, 2'd2, 1'b1, 1'b0, 4'd0), 4'd1, 1'b0, 1'b0, 1);
`endif
    drain();

    // R2=A, R3=R2+R2 sets C, then R2=R2^R2 holds C; rd_data shows old R2 through EXEC
    issue(mk(3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 4'hA), 4'hA, 1'b0, 1'b0, 1);
    issue(mk(3'd0, 2'd3, 2'd2, 2'd2, 1'b0, 1'b0, 4'd0), 4'h4, 1'b0, 1'b1, 1);
    drain();
    rd_addr = 2'd2;
    issue(mk(3'd5, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0, 4'd0), 4'h0, 1'b1, 1'b1, 1);
    chk("rd_pre_write", 32'(rd_data), 32'hA);
    @(posedge clk);
    #1 chk("rd_post_write", 32'(rd_data), 32'h0);
    drain();

    // instr_valid held high: accepted every third cycle
    @(negedge clk);
    instr = mk(3'd2, 2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 4'd6);
    instr_valid = 1'b1;
    acc = 0;
    last = -1;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) begin
        exp_t e;
        e.y = 4'd6; e.z = 1'b0; e.c = 1'b1; e.cyc = cyc + 2;
        exp_q.push_back(e);
        $display("stream accept at step %0d", i);
        if (last >= 0) chk("accept_spacing", 32'(i - last), 32'd3);
        last = i;
        acc++;
      end
      chk("ready_vs_busy", 32'(instr_ready), 32'(!busy));
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd3);
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
